program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the instruction-memory word-address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum idle cycles between bytes mid-frame.
REQ-003 Port clk: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous active-low reset.
REQ-005 Port rx_valid: input, 1 bit, a byte is offered on rx_data.
REQ-006 Port rx_data: input, 8 bits, the offered byte.
REQ-007 Port rx_ready: output, 1 bit, the loader accepts a byte; transfer occurs when rx_valid and rx_ready are both high on a clock edge.
REQ-008 Port imem_we: output, 1 bit, instruction-memory write strobe.
REQ-009 Port imem_addr: output, ADDR_W bits, word address, counting by 1 per instruction to match PC+1 sequencing.
REQ-010 Port imem_wdata: output, 32 bits, instruction word to write.
REQ-011 Port core_rst_n: output, 1 bit, active-low hold of the CPU core and its PC.
REQ-012 Port load_done: output, 1 bit, the last frame loaded with a valid checksum.
REQ-013 Port load_error: output, 1 bit, the last frame failed.

Function
REQ-014 Frame format SHALL be: magic 0xA5; count low byte; count high byte; count words, 4 bytes each, little-endian; 1 checksum byte.
REQ-015 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE and ERROR.
REQ-016 In IDLE, DONE and ERROR, an accepted 0xA5 SHALL go to LEN_LO and clear load_done, load_error and the word/byte counters; other bytes SHALL be discarded.
REQ-017 In LEN_LO and LEN_HI, accepted bytes SHALL load the 16-bit count, then go to DATA, or to CSUM if the count is 0.
REQ-018 A count greater than 2^ADDR_W SHALL go to ERROR after the LEN_HI byte.
REQ-019 In DATA, byte k of a word SHALL occupy bits [8k+7:8k]; after the 4th byte is accepted, imem_we SHALL pulse high for exactly 1 cycle on the next cycle, with imem_addr set to the word index (starting at 0) and imem_wdata set to the assembled word.
REQ-020 After word count-1 is accepted, the FSM SHALL go to CSUM.
REQ-021 The checksum SHALL be the sum modulo 256 of all payload bytes only.
REQ-022 In CSUM, a matching byte SHALL go to DONE and set load_done; a mismatch SHALL go to ERROR and set load_error.
REQ-023 core_rst_n SHALL be high only in DONE, and low in every other state.
REQ-024 rx_ready SHALL be high in every state out of reset; the loader SHALL never stall the source.
REQ-025 In LEN_LO through CSUM, if TIMEOUT consecutive cycles pass with no accepted byte, the FSM SHALL go to ERROR; the idle counter SHALL reset on every accepted byte.
REQ-026 ERROR SHALL persist, with the core held in reset, until the next magic byte.
REQ-027 load_done and load_error SHALL never both be high.

Reset
REQ-028 While rst is low: the state SHALL be IDLE, and rx_ready, imem_we, core_rst_n, load_done and load_error SHALL be 0.
REQ-029 While rst is low, imem_addr, imem_wdata, the counters and the checksum SHALL be 0.
REQ-030 A reset asserted mid-frame SHALL abandon the frame immediately; no further imem_we pulse SHALL occur for that frame.
REQ-031 rx_ready SHALL rise on the first clock edge after rst deasserts.

Structure
REQ-032 A shared package loader_pkg SHALL hold the state enum, LOADER_MAGIC (8'hA5) and the default TIMEOUT.
REQ-033 The block SHALL be a single module with no sub-modules; the FSM, byte assembler, checksum adder and idle counter SHALL be inline.

Verification
REQ-034 Send A5 02 00, then 13 00 00 00, then 93 00 10 00, then checksum B6 -> two imem_we pulses: addr 0 with 0x00000013, addr 1 with 0x00100093; load_done=1; core_rst_n=1.
REQ-035 Send the same frame with checksum B7 -> both writes occur; load_error=1; core_rst_n stays 0.
REQ-036 Send A5 00 00 00 -> no imem_we pulse; load_done=1.
REQ-037 Send A5 01 04 -> ERROR after the 3rd byte with ADDR_W=10; no writes.
REQ-038 Send A5 01 00 13, then idle for 1024 cycles -> ERROR; then a valid frame -> DONE.
REQ-039 Assert rst after the 2nd data byte -> all outputs 0 at once; the next frame loads from addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the serial program loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] LOADER_MAGIC   = 8'hA5;
    localparam int         LOADER_TIMEOUT = 1024;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream frame loader writing instruction memory and holding the core
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = LOADER_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_error
);

    localparam int          IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    loader_state_t state_q;
    loader_state_t state_next;

    logic [15:0]       count_q;
    logic [15:0]       word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       word_asm_q;
    logic [7:0]        csum_q;
    logic [IDLE_W-1:0] idle_cnt_q;

    logic        accept;
    logic        in_frame;
    logic        is_magic;
    logic [15:0] len_in;
    logic        last_byte_of_word;
    logic        last_word;
    logic        idle_expired;

    assign accept            = rx_valid && rx_ready;
    assign is_magic          = (rx_data == LOADER_MAGIC);
    assign in_frame          = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                               (state_q == DATA)   || (state_q == CSUM);
    assign len_in            = {rx_data, count_q[7:0]};
    assign last_byte_of_word = (byte_idx_q == 2'd3);
    assign last_word         = (word_idx_q == (count_q - 16'd1));
    assign idle_expired      = in_frame && !accept &&
                               (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

    // The core only runs once a frame has been loaded and its checksum verified.
    assign core_rst_n = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state decode; a stalled source mid-frame overrides any byte-driven move.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (accept && is_magic) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    if ({16'd0, len_in} > MAX_WORDS) begin
                        state_next = ERROR;
                    end else if (len_in == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && last_byte_of_word && last_word) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = (rx_data == csum_q) ? DONE : ERROR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (idle_expired) begin
            state_next = ERROR;
        end
    end

    // Handshake, byte assembly, checksum, idle timer, memory write and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_asm_q <= '0;
            csum_q     <= '0;
            idle_cnt_q <= '0;
        end else begin
            rx_ready <= 1'b1;
            imem_we  <= 1'b0;

            if (!in_frame || accept) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end

            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (accept && is_magic) begin
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        count_q    <= '0;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                        word_asm_q <= '0;
                        csum_q     <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        count_q[7:0] <= rx_data;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        count_q[15:8] <= rx_data;
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum_q     <= csum_q + rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_asm_q[7:0]   <= rx_data;
                            2'd1: word_asm_q[15:8]  <= rx_data;
                            2'd2: word_asm_q[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx_q[ADDR_W-1:0];
                                imem_wdata <= {rx_data, word_asm_q};
                                word_idx_q <= word_idx_q + 16'd1;
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase

            // Flags are set only on entry, so the two can never be high together.
            if (state_q == CSUM && state_next == DONE) begin
                load_done <= 1'b1;
            end
            if (state_q != ERROR && state_next == ERROR) begin
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              load_done;
    logic              load_error;

    program_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    logic        prev_we = 1'b0;
    logic [31:0] words [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (imem_we) begin
            writes_seen++;
            if (prev_we) begin
                check("we_single_cycle", 64'(prev_we), 64'(0));
            end
            if (exp_q.size() == 0) begin
                check("unexpected_we", 64'(imem_we), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(imem_addr), 64'(e.addr));
                check("wr_data", 64'(imem_wdata), 64'(e.data));
            end
        end
        if (load_done && load_error) begin
            check("done_error_excl", 64'(load_error), 64'(0));
        end
        prev_we = imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w);
        wr_t e;
        e.addr = idx[ADDR_W-1:0];
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] delta);
        logic [7:0] sum = 8'd0;
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            send_word(i, words[i]);
            for (int k = 0; k < 4; k++) begin
                sum = sum + words[i][8*k +: 8];
            end
        end
        send_byte(sum + delta);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic core);
        check({tag, "_done"}, 64'(load_done), 64'(done));
        check({tag, "_error"}, 64'(load_error), 64'(err));
        check({tag, "_core"}, 64'(core_rst_n), 64'(core));
    endtask

    initial begin
        int w0;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 64'(rx_ready), 64'(0));
        check("rst_we", 64'(imem_we), 64'(0));
        check("rst_addr", 64'(imem_addr), 64'(0));
        check("rst_wdata", 64'(imem_wdata), 64'(0));
        check_status("rst", 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        #1;
        check("ready_before_edge", 64'(rx_ready), 64'(0));
        @(posedge clk);
        #1;
        check("ready_after_edge", 64'(rx_ready), 64'(1));

        // Two-word frame with correct checksum (0xB6).
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        send_frame(2, 8'd0);
        check_status("good2", 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("good2_writes", 64'(writes_seen), 64'(2));
        check("good2_q_empty", 64'(exp_q.size()), 64'(0));

        // Non-magic bytes are discarded in DONE.
        send_byte(8'h13);
        check_status("done_junk", 1'b1, 1'b0, 1'b1);

        // Same frame, checksum off by one (0xB7).
        send_frame(2, 8'd1);
        check_status("badsum", 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("badsum_writes", 64'(writes_seen), 64'(4));

        // Empty frame.
        send_frame(0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check_status("empty", 1'b1, 1'b0, 1'b1);
        check("empty_writes", 64'(writes_seen), 64'(4));

        // Count 1025 exceeds 2^ADDR_W.
        send_byte(8'hA5);
        send_byte(8'h01);
        check("len_pending_error", 64'(load_error), 64'(0));
        send_byte(8'h04);
        check_status("too_long", 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("too_long_persist", 64'(load_error), 64'(1));
        check("too_long_writes", 64'(writes_seen), 64'(4));

        // Count exactly 2^ADDR_W is accepted; then let it stall out.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h04);
        check_status("max_len", 1'b0, 1'b0, 1'b0);
        repeat (TIMEOUT) @(posedge clk);
        #1;
        check("max_len_timeout", 64'(load_error), 64'(1));

        // Timeout boundary: stalled after one data byte.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("timeout_minus1", 64'(load_error), 64'(0));
        @(posedge clk);
        #1;
        check_status("timeout", 1'b0, 1'b1, 1'b0);
        w0 = writes_seen;
        words[0] = 32'h8765_4321;
        send_frame(1, 8'd0);
        check_status("after_timeout", 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("after_timeout_writes", 64'(writes_seen), 64'(w0 + 1));

        // Reset mid-frame after the 2nd data byte.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        rst = 1'b0;
        #1;
        check("midrst_ready", 64'(rx_ready), 64'(0));
        check("midrst_we", 64'(imem_we), 64'(0));
        check("midrst_addr", 64'(imem_addr), 64'(0));
        check("midrst_wdata", 64'(imem_wdata), 64'(0));
        check_status("midrst", 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_write", 64'(writes_seen), 64'(w0 + 1));

        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h1234_5678;
        words[2] = 32'h0000_0001;
        send_frame(3, 8'd0);
        check_status("post_rst", 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_writes", 64'(writes_seen), 64'(w0 + 4));
        check("final_q_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
